store_rmw: RTL and testbench

- Store-side counterpart of the load data-extension path.
- Accepts a byte, halfword or word store from the LSU and performs it on a word-wide data memory that has no byte enables.
- Sub-word stores are done as read-modify-write: read the word, merge the shifted store data into the correct lane(s), write the word back.
- Sits between the LSU store request and the data memory port. Handshakes on both sides, one store in flight at a time.

---
 rtl/store_rmw_pkg.sv | 35 +++
 rtl/store_rmw_if.sv | 48 ++++
 rtl/store_rmw_merge.sv | 37 +++
 rtl/store_rmw.sv | 139 +++++++++++++
 tb/tb_store_rmw.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/store_rmw_pkg.sv
// store_rmw_pkg: shared definitions for the LSU store read-modify-write path.
//   - ST_SB / ST_SH / ST_SW / ST_ILL : access size encoding, shared with the
//     load path's size field.
//   - state_t                        : store_rmw FSM state encoding.
//   - misaligned()                   : true when an access does not sit on its
//                                      natural boundary.
//   - bad_request()                  : misaligned or illegal size; such
//                                      requests are rejected with no memory access.
package store_rmw_pkg;

  localparam logic [1:0] ST_SB  = 2'b00;
  localparam logic [1:0] ST_SH  = 2'b01;
  localparam logic [1:0] ST_SW  = 2'b10;
  localparam logic [1:0] ST_ILL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_REQ  = 2'd1,
    S_RD_WAIT = 2'd2,
    S_WRITE   = 2'd3
  } state_t;

  function automatic logic misaligned(input logic [1:0] sel, input logic [1:0] lo);
    case (sel)
      ST_SH:   return lo[0];
      ST_SW:   return (lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic bad_request(input logic [1:0] sel, input logic [1:0] lo);
    return misaligned(sel, lo) || (sel == ST_ILL);
  endfunction

endpackage

// File: rtl/store_rmw_if.sv
// store_rmw_if: bundles the LSU store request port and the data memory port
// of store_rmw.
//   st_*      : store request (valid, ready, byte address, data, size select)
//   mem_*     : word-wide memory port (address, read strobe, read data/valid,
//               write strobe, write data)
//   done, err : one-cycle completion / rejection pulses
// Modports: slave = store_rmw's view, master = the LSU + memory environment.
//
// Handshake: a store request transfers on a rising edge where st_valid and
// st_ready are both high; the requester holds st_* stable while st_valid is
// high and st_ready is low. The memory side has no back-pressure: mem_re and
// mem_we are single-cycle strobes, and mem_rdata is taken in the cycle where
// mem_rvalid is high.
interface store_rmw_if #(
  parameter int ADDR_W = 32
);
  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic [1:0]        st_sel;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;
  logic              mem_we;
  logic [31:0]       mem_wdata;

  logic              done;
  logic              err;

  modport slave (
    input  st_valid, st_addr, st_data, st_sel,
    output st_ready,
    output mem_addr, mem_re, mem_we, mem_wdata,
    input  mem_rvalid, mem_rdata,
    output done, err
  );

  modport master (
    output st_valid, st_addr, st_data, st_sel,
    input  st_ready,
    input  mem_addr, mem_re, mem_we, mem_wdata,
    output mem_rvalid, mem_rdata,
    input  done, err
  );
endinterface

// File: rtl/store_rmw_merge.sv
// store_rmw_merge: combinational little-endian lane merge.
//   rdata  : word read from memory
//   data   : right-justified store data
//   sel    : access size (ST_SB / ST_SH / ST_SW)
//   lane   : byte address bits [1:0]; sh only looks at lane[1]
//   merged : rdata with the addressed byte/halfword replaced (data for sw)
module store_rmw_merge
  import store_rmw_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] data,
  input  logic [1:0]  sel,
  input  logic [1:0]  lane,
  output logic [31:0] merged
);

  always_comb begin
    merged = rdata;
    case (sel)
      ST_SB: begin
        case (lane)
          2'd0:    merged[7:0]   = data[7:0];
          2'd1:    merged[15:8]  = data[7:0];
          2'd2:    merged[23:16] = data[7:0];
          default: merged[31:24] = data[7:0];
        endcase
      end
      ST_SH: begin
        if (lane[1]) merged[31:16] = data[15:0];
        else         merged[15:0]  = data[15:0];
      end
      ST_SW:   merged = data;
      default: merged = rdata;
    endcase
  end

endmodule

// File: rtl/store_rmw.sv
// store_rmw: performs byte/halfword/word stores on a word-wide data memory
// without byte enables. Sub-word stores read the word, merge the new lane(s)
// and write the word back; aligned word stores write directly. One store in
// flight; the request is captured on acceptance.
// Ports:
//   i_clk     : clock, rising edge
//   i_reset   : asynchronous active-low reset
//   bus       : store_rmw_if.slave (store request, memory port, done/err)
//   dbg_state : current FSM state
// Parameters:
//   ADDR_W     : byte address width
//   RD_TIMEOUT : RD_WAIT cycles without mem_rvalid before the store is aborted (>=1)
module store_rmw
  import store_rmw_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int RD_TIMEOUT = 15
) (
  input  logic          i_clk,
  input  logic          i_reset,
  store_rmw_if.slave    bus,
  output state_t        dbg_state
);

  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT);

  state_t            state;
  logic [ADDR_W-1:0] cap_addr;
  logic [31:0]       cap_data;
  logic [1:0]        cap_sel;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;

  logic              st_ready_q;
  logic              mem_re_q;
  logic              mem_we_q;
  logic [31:0]       mem_wdata_q;
  logic              done_q;
  logic              err_q;

  logic [31:0]       merged;

  store_rmw_merge u_merge (
    .rdata  (bus.mem_rdata),
    .data   (cap_data),
    .sel    (cap_sel),
    .lane   (cap_addr[1:0]),
    .merged (merged)
  );

  assign cnt_inc = cnt + 1'b1;

  // Address comes straight from the capture register, so it is stable from
  // RD_REQ through WRITE without a separate output register.
  assign bus.mem_addr  = {cap_addr[ADDR_W-1:2], 2'b00};
  assign bus.st_ready  = st_ready_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign dbg_state     = state;

  // Outputs are registered alongside the state transition, so each strobe is
  // high exactly during the state it belongs to.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= S_IDLE;
      cap_addr    <= '0;
      cap_data    <= '0;
      cap_sel     <= '0;
      cnt         <= '0;
      st_ready_q  <= 1'b1;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mem_re_q <= 1'b0;
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.st_valid && st_ready_q) begin
            cap_addr <= bus.st_addr;
            cap_data <= bus.st_data;
            cap_sel  <= bus.st_sel;
            if (bad_request(bus.st_sel, bus.st_addr[1:0])) begin
              // Rejected in place: ready stays high, no memory access.
              err_q <= 1'b1;
            end else if (bus.st_sel == ST_SW) begin
              mem_wdata_q <= bus.st_data;
              mem_we_q    <= 1'b1;
              done_q      <= 1'b1;
              st_ready_q  <= 1'b0;
              state       <= S_WRITE;
            end else begin
              mem_re_q   <= 1'b1;
              st_ready_q <= 1'b0;
              state      <= S_RD_REQ;
            end
          end
        end
        S_RD_REQ: begin
          // mem_rvalid is deliberately not looked at here.
          cnt   <= '0;
          state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (bus.mem_rvalid) begin
            mem_wdata_q <= merged;
            mem_we_q    <= 1'b1;
            done_q      <= 1'b1;
            state       <= S_WRITE;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == CNT_LAST) begin
              err_q      <= 1'b1;
              st_ready_q <= 1'b1;
              state      <= S_IDLE;
            end
          end
        end
        S_WRITE: begin
          st_ready_q <= 1'b1;
          state      <= S_IDLE;
        end
        default: begin
          st_ready_q <= 1'b1;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_rmw.sv
// tb_store_rmw: self-checking bench for store_rmw. A word memory model in the
// bench answers reads and tracks what the stored words must become.
module tb_store_rmw;
  import store_rmw_pkg::*;

  localparam int ADDR_W     = 32;
  localparam int RD_TIMEOUT = 15;

  logic   clk = 1'b0;
  logic   rst_n;
  state_t dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Word memory keyed by word-aligned byte address.
  logic [31:0] mem [logic [31:0]];

  store_rmw_if #(.ADDR_W(ADDR_W)) bus ();

  store_rmw #(
    .ADDR_W     (ADDR_W),
    .RD_TIMEOUT (RD_TIMEOUT)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] mem_read(input logic [31:0] waddr);
    if (!mem.exists(waddr)) mem[waddr] = $urandom;
    return mem[waddr];
  endfunction

  function automatic logic [31:0] expect_word(input logic [31:0] old, input logic [31:0] data,
                                              input logic [1:0] sel, input logic [1:0] lo);
    int shift;
    if (sel == 2'b00) begin
      shift = 8 * int'(lo);
      return (old & ~(32'h0000_00FF << shift)) | ((data & 32'h0000_00FF) << shift);
    end else if (sel == 2'b01) begin
      shift = 16 * int'(lo[1]);
      return (old & ~(32'h0000_FFFF << shift)) | ((data & 32'h0000_FFFF) << shift);
    end
    return data;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 32'(bus.st_ready), 32'd1);
    check({tag, "_strobes"}, {28'd0, bus.mem_re, bus.mem_we, bus.done, bus.err}, 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
  endtask

  // ---------------- driver ----------------
  // Cycle k counts from the accepting edge: cycle 1 is the cycle right after it.
  // lat: mem_rvalid is given in cycle 1+lat (lat>=1). timeout: never answer.
  // spurious: put a junk rvalid into cycle 1, which must be ignored.
  task automatic run_store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] sel,
                           input int lat, input bit timeout, input bit spurious);
    bit          bad;
    logic [31:0] waddr, old, exp_w, we_data, we_addr, re_addr;
    int          re_cnt, re_cyc, we_cyc, done_cyc, err_cyc;
    bad    = (sel == 2'b11) || (sel == 2'b01 && addr[0]) || (sel == 2'b10 && addr[1:0] != 2'b00);
    waddr  = {addr[31:2], 2'b00};
    re_cnt = 0; re_cyc = -1; we_cyc = -1; done_cyc = -1; err_cyc = -1;
    we_data = '0; we_addr = '0; re_addr = '0;

    @(negedge clk);
    check("ready_before_accept", 32'(bus.st_ready), 32'd1);
    bus.st_valid = 1'b1;
    bus.st_addr  = addr;
    bus.st_data  = data;
    bus.st_sel   = sel;
    @(posedge clk);

    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.mem_re) begin re_cnt++; re_cyc = k; re_addr = bus.mem_addr; end
      if (bus.mem_we && we_cyc < 0) begin we_cyc = k; we_data = bus.mem_wdata; we_addr = bus.mem_addr; end
      if (bus.done && done_cyc < 0) done_cyc = k;
      if (bus.err && err_cyc < 0) err_cyc = k;
      if (k == 1) begin
        // Request is captured; later changes must not matter.
        bus.st_valid = 1'b0;
        bus.st_addr  = $urandom;
        bus.st_data  = $urandom;
        bus.st_sel   = 2'($urandom_range(0, 3));
      end
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = $urandom;
      if (!bad && sel != 2'b10 && !timeout) begin
        if (k == 1 + lat) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = mem_read(waddr);
        end else if (spurious && k == 1) begin
          bus.mem_rvalid = 1'b1;
        end
      end
      if (we_cyc > 0 || err_cyc > 0) break;
    end
    bus.mem_rvalid = 1'b0;

    if (bad) begin
      check("bad_err_cycle", err_cyc, 1);
      check("bad_no_we", we_cyc, -1);
      check("bad_no_re", re_cnt, 0);
      check("bad_ready_c1", 32'(bus.st_ready), 32'd1);
    end else if (sel == 2'b10) begin
      check("sw_we_cycle", we_cyc, 1);
      check("sw_done_cycle", done_cyc, 1);
      check("sw_no_re", re_cnt, 0);
      check("sw_addr", we_addr, waddr);
      check("sw_wdata", we_data, data);
      mem[waddr] = data;
    end else begin
      check("rmw_re_count", re_cnt, 1);
      check("rmw_re_cycle", re_cyc, 1);
      check("rmw_re_addr", re_addr, waddr);
      if (timeout) begin
        check("to_err_cycle", err_cyc, RD_TIMEOUT + 2);
        check("to_no_we", we_cyc, -1);
      end else begin
        old   = mem_read(waddr);
        exp_w = expect_word(old, data, sel, addr[1:0]);
        check("rmw_we_cycle", we_cyc, 2 + lat);
        check("rmw_done_cycle", done_cyc, 2 + lat);
        check("rmw_no_err", err_cyc, -1);
        check("rmw_addr", we_addr, waddr);
        check("rmw_wdata", we_data, exp_w);
        mem[waddr] = exp_w;
      end
    end

    // Strobes are single-cycle and the block is ready again.
    @(negedge clk);
    check_idle_outputs("after_store");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n          = 1'b0;
    bus.st_valid   = 1'b0;
    bus.st_addr    = '0;
    bus.st_data    = '0;
    bus.st_sel     = '0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_mem_addr", bus.mem_addr, 32'd0);
    check("reset_wdata", bus.mem_wdata, 32'd0);
    rst_n = 1'b1;

    // Directed cases.
    run_store(32'h0000_0100, 32'hDEAD_BEEF, 2'b10, 1, 1'b0, 1'b0);
    mem[32'h200] = 32'h1122_3344;
    run_store(32'h0000_0203, 32'h0000_00AA, 2'b00, 1, 1'b0, 1'b0);
    check("sb_0x203_mem", mem[32'h200], 32'hAA22_3344);
    mem[32'h300] = 32'h1122_3344;
    run_store(32'h0000_0302, 32'h0000_CAFE, 2'b01, 1, 1'b0, 1'b0);
    check("sh_0x302_mem", mem[32'h300], 32'hCAFE_3344);
    mem[32'h300] = 32'h1122_3344;
    run_store(32'h0000_0300, 32'h0000_CAFE, 2'b01, 2, 1'b0, 1'b1);
    check("sh_0x300_mem", mem[32'h300], 32'h1122_CAFE);
    run_store(32'h0000_0401, 32'h0000_1234, 2'b01, 1, 1'b0, 1'b0);
    run_store(32'h0000_0400, 32'h0000_1234, 2'b11, 1, 1'b0, 1'b0);
    run_store(32'h0000_0402, 32'h1234_5678, 2'b10, 1, 1'b0, 1'b0);
    run_store(32'h0000_0501, 32'h0000_0055, 2'b00, 1, 1'b1, 1'b0);
    run_store(32'h0000_0502, 32'h0000_0066, 2'b00, 3, 1'b0, 1'b0);

    // Reset in RD_WAIT with rvalid arriving in the same cycle.
    @(negedge clk);
    bus.st_valid = 1'b1; bus.st_addr = 32'h0000_0601; bus.st_data = 32'h77; bus.st_sel = 2'b00;
    @(posedge clk);
    @(negedge clk);
    bus.st_valid = 1'b0;
    check("rst_mid_re", 32'(bus.mem_re), 32'd1);
    @(negedge clk);
    check("rst_mid_state", 32'(dbg_state), 32'(S_RD_WAIT));
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hFFFF_FFFF;
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst_mid_held");
    check("rst_mid_wdata", bus.mem_wdata, 32'd0);
    bus.mem_rvalid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("rst_mid_release");
    check("rst_mid_addr", bus.mem_addr, 32'd0);

    // Randomized stores over a small address window so words get reused.
    for (int i = 0; i < 150; i++) begin
      run_store(32'($urandom_range(0, 63)), $urandom, 2'($urandom_range(0, 3)),
                $urandom_range(1, 5), ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
